// File: rtl/instruction_decode_queue.sv
// RV32 decode-on-enqueue FIFO: instructions are decoded as they are accepted,
// and the head entry's decoded bundle is presented over a valid/ready handshake.
module instruction_decode_queue #(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instruction,
    input  logic [PC_WIDTH-1:0]       in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_WIDTH-1:0]       out_pc,
    output logic [2:0]                instruction_type,
    output logic [6:0]                opcode,
    output logic [2:0]                funct3,
    output logic [6:0]                funct7,
    output logic [4:0]                read_index_1,
    output logic [4:0]                read_index_2,
    output logic [4:0]                write_index,
    output logic                      read_enable_1,
    output logic                      read_enable_2,
    output logic                      write_enable,
    output logic [31:0]               immediate,
    output logic                      illegal,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;
    localparam logic [2:0] T_ILLEGAL = 3'd7;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [2:0]          itype;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                re1;
        logic                re2;
        logic                we;
        logic [31:0]         imm;
        logic                illegal;
    } entry_t;

    entry_t              dec;
    entry_t              mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       occ_q;
    logic                push;
    logic                pop;
    logic [2:0]          base_type;
    logic                bad;
    logic [31:0]         ins;

    assign ins = in_instruction;

    always_comb begin
        base_type = T_I;
        bad       = 1'b0;
        unique case (ins[6:2])
            5'b00000: bad = (ins[14:12] == 3'd3) || (ins[14:12] == 3'd6) || (ins[14:12] == 3'd7);
            5'b00001, 5'b00011, 5'b00100, 5'b00110, 5'b11100: base_type = T_I;
            5'b11001: bad = (ins[14:12] != 3'd0);
            5'b11000: begin
                base_type = T_B;
                bad       = (ins[14:12] == 3'd2) || (ins[14:12] == 3'd3);
            end
            5'b01100: begin
                base_type = T_R;
                bad       = !((ins[31:25] == 7'h00) || (ins[31:25] == 7'h20) || (ins[31:25] == 7'h01));
            end
            5'b10100: base_type = T_R;
            5'b01000: begin
                base_type = T_S;
                bad       = (ins[14:12] > 3'd2);
            end
            5'b01001: base_type = T_S;
            5'b00101, 5'b01101: base_type = T_U;
            5'b11011: base_type = T_J;
            default: bad = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) begin
            bad = 1'b1;
        end
    end

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = ins[6:0];
        dec.funct3  = ins[14:12];
        dec.funct7  = ins[31:25];
        dec.rs1     = ins[19:15];
        dec.rs2     = ins[24:20];
        dec.rd      = ins[11:7];
        dec.itype   = bad ? T_ILLEGAL : base_type;
        dec.illegal = bad;
        case (dec.itype)
            T_I: begin
                {dec.re1, dec.re2, dec.we} = 3'b101;
                dec.imm = {{20{ins[31]}}, ins[31:20]};
            end
            T_S: begin
                {dec.re1, dec.re2, dec.we} = 3'b110;
                dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            T_B: begin
                {dec.re1, dec.re2, dec.we} = 3'b110;
                dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            T_U: begin
                {dec.re1, dec.re2, dec.we} = 3'b001;
                dec.imm = {ins[31:12], 12'b0};
            end
            T_J: begin
                {dec.re1, dec.re2, dec.we} = 3'b001;
                dec.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            T_R: {dec.re1, dec.re2, dec.we} = 3'b111;
            default: {dec.re1, dec.re2, dec.we} = 3'b000;
        endcase
        // x0 is never a real destination
        if (ins[11:7] == 5'd0) begin
            dec.we = 1'b0;
        end
    end

    assign in_ready  = (occ_q < FULL_COUNT);
    assign out_valid = (occ_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + CW'(1);
                2'b01:   occ_q <= occ_q - CW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= dec;
        end
    end

    assign out_pc           = mem[rd_ptr].pc;
    assign instruction_type = mem[rd_ptr].itype;
    assign opcode           = mem[rd_ptr].opcode;
    assign funct3           = mem[rd_ptr].funct3;
    assign funct7           = mem[rd_ptr].funct7;
    assign read_index_1     = mem[rd_ptr].rs1;
    assign read_index_2     = mem[rd_ptr].rs2;
    assign write_index      = mem[rd_ptr].rd;
    assign read_enable_1    = mem[rd_ptr].re1;
    assign read_enable_2    = mem[rd_ptr].re2;
    assign write_enable     = mem[rd_ptr].we;
    assign immediate        = mem[rd_ptr].imm;
    assign illegal          = mem[rd_ptr].illegal;
    assign occupancy        = occ_q;

endmodule
